e6_gpio_in_cond: RTL and testbench

Input conditioning stage that sits directly upstream of the E6 GPIO AXI4-Lite register block. It synchronises raw pad inputs, debounces them with a programmable per-bit stability counter, and detects rising and falling edges. It also keeps sticky per-bit interrupt status that the register block reads and clears. The register block consumes `data_o`, `irq_status` and `irq_o`, and drives `db_limit`, `rise_en`, `fall_en` and `irq_clr` from its slave registers.

---
 rtl/e6_gpio_pkg.sv | 24 ++
 rtl/e6_gpio_db_bit.sv | 83 ++++++++
 rtl/e6_gpio_in_cond.sv | 44 ++++
 tb/tb_e6_gpio_in_cond.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/e6_gpio_pkg.sv
// Shared constants and types for the E6 GPIO input conditioner and its register block.
package e6_gpio_pkg;

  localparam int GPIO_WIDTH       = 32;
  localparam int GPIO_SYNC_STAGES = 2;
  localparam int GPIO_DB_W        = 16;

  typedef logic [GPIO_WIDTH-1:0] gpio_vec_t;

  typedef enum logic [1:0] {
    DB_HOLD   = 2'd0,
    DB_COUNT  = 2'd1,
    DB_COMMIT = 2'd2
  } db_act_e;

  // A mismatch only commits once the counter has reached the limit. The compare
  // is >= so a limit lowered mid-count still commits on the next mismatching cycle.
  function automatic db_act_e db_action(input logic level_match, input logic limit_reached);
    if (level_match)   return DB_HOLD;
    if (limit_reached) return DB_COMMIT;
    return DB_COUNT;
  endfunction

endpackage

// File: rtl/e6_gpio_db_bit.sv
// One GPIO bit: synchroniser chain, debounce counter, edge pulses and sticky status.
// SYNC_STAGES must be in 2..4.
module e6_gpio_db_bit
  import e6_gpio_pkg::*;
#(
  parameter int SYNC_STAGES = GPIO_SYNC_STAGES,
  parameter int DB_W        = GPIO_DB_W
) (
  input  logic            ACLK,
  input  logic            ARESET,
  input  logic            pad_i,
  input  logic [DB_W-1:0] db_limit_i,
  input  logic            rise_en_i,
  input  logic            fall_en_i,
  input  logic            irq_clr_i,
  output logic            data_o,
  output logic            rise_o,
  output logic            fall_o,
  output logic            irq_status_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   level_q, level_d;
  logic [DB_W-1:0]        cnt_q, cnt_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   status_q, status_d;
  logic                   s;
  db_act_e                act;

  assign s = sync_q[SYNC_STAGES-1];

  // NOTE: every signal written here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], pad_i};
    level_d = level_q;
    cnt_d   = '0;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    act     = db_action(s == level_q, cnt_q >= db_limit_i);

    unique case (act)
      DB_HOLD:   cnt_d = '0;
      DB_COUNT:  cnt_d = cnt_q + DB_W'(1);
      DB_COMMIT: begin
        level_d = s;
        rise_d  = s;
        fall_d  = ~s;
      end
      default:   cnt_d = '0;
    endcase

    // Set is ORed in after the clear so a same-cycle set wins.
    status_d = (status_q & ~irq_clr_i) | (rise_q & rise_en_i) | (fall_q & fall_en_i);
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      sync_q   <= '0;
      level_q  <= 1'b0;
      cnt_q    <= '0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      status_q <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      level_q  <= level_d;
      cnt_q    <= cnt_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      status_q <= status_d;
    end
  end

  assign data_o       = level_q;
  assign rise_o       = rise_q;
  assign fall_o       = fall_q;
  assign irq_status_o = status_q;

endmodule

// File: rtl/e6_gpio_in_cond.sv
// GPIO input conditioning: WIDTH independent debounce bits plus the combined interrupt line.
module e6_gpio_in_cond
  import e6_gpio_pkg::*;
#(
  parameter int WIDTH       = GPIO_WIDTH,
  parameter int SYNC_STAGES = GPIO_SYNC_STAGES,
  parameter int DB_W        = GPIO_DB_W
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic [WIDTH-1:0] gpio_i,
  input  logic [DB_W-1:0]  db_limit,
  input  logic [WIDTH-1:0] rise_en,
  input  logic [WIDTH-1:0] fall_en,
  input  logic [WIDTH-1:0] irq_clr,
  output logic [WIDTH-1:0] data_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic [WIDTH-1:0] irq_status,
  output logic             irq_o
);

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    e6_gpio_db_bit #(
      .SYNC_STAGES (SYNC_STAGES),
      .DB_W        (DB_W)
    ) u_bit (
      .ACLK         (ACLK),
      .ARESET       (ARESET),
      .pad_i        (gpio_i[g]),
      .db_limit_i   (db_limit),
      .rise_en_i    (rise_en[g]),
      .fall_en_i    (fall_en[g]),
      .irq_clr_i    (irq_clr[g]),
      .data_o       (data_o[g]),
      .rise_o       (rise_o[g]),
      .fall_o       (fall_o[g]),
      .irq_status_o (irq_status[g])
    );
  end

  assign irq_o = |irq_status;

endmodule

// File: tb/tb_e6_gpio_in_cond.sv
// Directed bench for e6_gpio_in_cond: expectations queued with the stimulus, checked after each edge.
module tb_e6_gpio_in_cond;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [31:0] gpio_i, rise_en, fall_en, irq_clr;
  logic [15:0] db_limit;
  logic [31:0] data_o, rise_o, fall_o, irq_status;
  logic        irq_o;

  int errors = 0;
  int checks = 0;

  typedef enum {S_DATA, S_RISE, S_FALL, S_STAT, S_IRQ} sel_e;
  typedef struct {
    string       tag;
    sel_e        sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];

  e6_gpio_in_cond dut (
    .ACLK       (ACLK),
    .ARESET     (ARESET),
    .gpio_i     (gpio_i),
    .db_limit   (db_limit),
    .rise_en    (rise_en),
    .fall_en    (fall_en),
    .irq_clr    (irq_clr),
    .data_o     (data_o),
    .rise_o     (rise_o),
    .fall_o     (fall_o),
    .irq_status (irq_status),
    .irq_o      (irq_o)
  );

  always #5 ACLK = ~ACLK;

  task automatic push(input string tag, input sel_e sel, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic expect_all(input string tag, input logic [31:0] d, input logic [31:0] r,
                            input logic [31:0] f, input logic [31:0] st, input logic irq);
    push({tag, ".data"}, S_DATA, d);
    push({tag, ".rise"}, S_RISE, r);
    push({tag, ".fall"}, S_FALL, f);
    push({tag, ".stat"}, S_STAT, st);
    push({tag, ".irq"},  S_IRQ,  {31'b0, irq});
  endtask

  function automatic logic [31:0] observe(input sel_e sel);
    case (sel)
      S_DATA:  return data_o;
      S_RISE:  return rise_o;
      S_FALL:  return fall_o;
      S_STAT:  return irq_status;
      default: return {31'b0, irq_o};
    endcase
  endfunction

  task automatic drain();
    exp_t        e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.sel);
      checks++;
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
      end
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge ACLK);
    #1;
  endtask

  initial begin
    ARESET   = 1'b1;
    gpio_i   = '1;
    db_limit = '0;
    rise_en  = '0;
    fall_en  = '0;
    irq_clr  = '0;

    // Reset with pads high: everything stays 0.
    for (int i = 0; i < 5; i++) begin
      tick(1);
      expect_all("reset", '0, '0, '0, '0, 1'b0);
      drain();
    end

    // Release: pads high show up as a normal rise at edge 3.
    ARESET = 1'b0;
    tick(2);
    expect_all("rel_e2", '0, '0, '0, '0, 1'b0);
    drain();
    tick(1);
    expect_all("rel_e3", '1, '1, '0, '0, 1'b0);
    drain();
    tick(1);
    expect_all("rel_e4", '1, '0, '0, '0, 1'b0);
    drain();

    // Drop all pads back to 0 with no debounce.
    gpio_i = '0;
    tick(3);
    expect_all("drop", '0, '0, '1, '0, 1'b0);
    drain();
    tick(2);

    // Debounce latency: db_limit=4, bit 0 commits at edge 7.
    db_limit = 16'd4;
    rise_en  = 32'h1;
    gpio_i   = 32'h1;
    tick(6);
    expect_all("lat_e6", '0, '0, '0, '0, 1'b0);
    drain();
    tick(1);
    expect_all("lat_e7", 32'h1, 32'h1, '0, '0, 1'b0);
    drain();
    tick(1);
    expect_all("lat_e8", 32'h1, '0, '0, 32'h1, 1'b1);
    drain();
    irq_clr = 32'h1;
    tick(1);
    irq_clr = '0;
    expect_all("lat_clr", 32'h1, '0, '0, '0, 1'b0);
    drain();

    // Glitch: bit 3 high for 3 cycles never commits.
    gpio_i = 32'h9;
    tick(3);
    gpio_i = 32'h1;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      expect_all("glitch", 32'h1, '0, '0, '0, 1'b0);
      drain();
    end

    // A clean rise on bit 3 needs the full latency, so the counter was back at 0.
    gpio_i = 32'h9;
    tick(6);
    push("b3_e6.data", S_DATA, 32'h1);
    drain();
    tick(1);
    push("b3_e7.data", S_DATA, 32'h9);
    push("b3_e7.rise", S_RISE, 32'h8);
    drain();

    // Set/clear collision on bit 5.
    db_limit = '0;
    fall_en  = 32'h20;
    gpio_i   = 32'h29;
    tick(5);
    push("b5_up.data", S_DATA, 32'h29);
    push("b5_up.stat", S_STAT, '0);
    drain();
    gpio_i = 32'h9;
    tick(3);
    push("b5_fall.fall", S_FALL, 32'h20);
    push("b5_fall.stat", S_STAT, '0);
    drain();
    irq_clr = 32'h20;
    tick(1);
    irq_clr = '0;
    expect_all("collide", 32'h9, '0, '0, 32'h20, 1'b1);
    drain();
    tick(2);
    push("b5_hold.stat", S_STAT, 32'h20);
    drain();
    irq_clr = 32'h20;
    tick(1);
    irq_clr = '0;
    push("b5_clr.stat", S_STAT, '0);
    push("b5_clr.irq",  S_IRQ,  '0);
    drain();

    // Limit lowered mid-count on bit 7 commits on the next edge.
    db_limit = 16'd100;
    gpio_i   = 32'h89;
    tick(10);
    push("b7_e10.data", S_DATA, 32'h9);
    drain();
    db_limit = 16'd2;
    tick(1);
    push("b7_e11.data", S_DATA, 32'h89);
    push("b7_e11.rise", S_RISE, 32'h80);
    drain();

    // Bits 0 and 31 toggle together with no debounce.
    db_limit = '0;
    tick(2);
    gpio_i = 32'h8000_0088;
    tick(2);
    expect_all("multi_e2", 32'h89, '0, '0, '0, 1'b0);
    drain();
    tick(1);
    expect_all("multi_e3", 32'h8000_0088, 32'h8000_0000, 32'h1, '0, 1'b0);
    drain();
    tick(1);
    expect_all("multi_e4", 32'h8000_0088, '0, '0, '0, 1'b0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
